// File: rtl/dmem_result_reader_pkg.sv
// Shared definitions for the data-memory read-back engine: FSM state codes,
// port-1 address-mux select codes and default bus widths.
package dmem_result_reader_pkg;

    localparam int DMEM_ADDR_W = 16;
    localparam int DMEM_DATA_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] MUX_CORE = 2'b00;
    localparam logic [1:0] MUX_TBWR = 2'b01;
    localparam logic [1:0] MUX_RDBK = 2'b10;

endpackage

// File: rtl/dmem_result_reader_rdbk_fifo.sv
// rdbk_fifo: synchronous output buffer for read-back words; a push and a pop
// in the same cycle on a full buffer is accepted and leaves occupancy unchanged.
module rdbk_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign count     = count_q;
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    // Head is forced to zero when empty so the streamed word reads 0 after reset.
    assign dout      = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + {{PW{1'b0}}, 1'b1};
                2'b01:   count_q <= count_q - {{PW{1'b0}}, 1'b1};
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dmem_result_reader.sv
// dmem_result_reader: sweeps a contiguous data-memory region through port 1 and
// streams the words over valid/ready. Optional checksum port: DUMP_CHECKSUM_EN.
module dmem_result_reader
    import dmem_result_reader_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int READ_LAT   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [1:0]        mux_sel,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   base_q, len_q, issued_q;
    logic [READ_LAT-1:0] pipe_q, pipe_d;
    logic [READ_LAT:0]   pipe_ext_s;
    logic [CW-1:0]       inflight_s;
    logic [CW:0]         occ_sum_s;
    logic [CW-1:0]       fifo_count_s;
    logic                fifo_empty_s, fifo_full_s;
    logic                credit_ok_s, mem_rd_s, last_issue_s;
    logic                push_s, pop_s, pending_s, drain_done_s, start_acc_s;

    assign start_acc_s = (state_q == ST_IDLE) && start;
    assign pending_s   = |pipe_q;
    assign push_s      = pipe_q[READ_LAT-1];
    assign pop_s       = !fifo_empty_s && out_ready;

    // Reads still in the return pipe reserve buffer space, so a push never meets a full FIFO.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight_s = inflight_s + CW'(pipe_q[i]);
        end
    end

    assign occ_sum_s    = (CW+1)'(fifo_count_s) + (CW+1)'(inflight_s);
    assign credit_ok_s  = !fifo_full_s && (occ_sum_s < (CW+1)'(FIFO_DEPTH));
    assign mem_rd_s     = (state_q == ST_ISSUE) && credit_ok_s;
    assign last_issue_s = mem_rd_s && (issued_q == (len_q - {{(ADDR_W-1){1'b0}}, 1'b1}));
    // The last word leaving this cycle already counts as drained, so done follows the final accept directly.
    assign drain_done_s = !pending_s &&
                          (fifo_empty_s || ((fifo_count_s == {{(CW-1){1'b0}}, 1'b1}) && pop_s));
    assign pipe_ext_s   = {pipe_q, mem_rd_s};
    assign pipe_d       = pipe_ext_s[READ_LAT-1:0];

    // Next-state logic for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (length != '0) ? ST_ISSUE : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (last_issue_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (drain_done_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, captured job parameters, issue counter and return pipe.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            pipe_q   <= '0;
        end else begin
            state_q <= state_d;
            pipe_q  <= pipe_d;
            if (start_acc_s) begin
                base_q   <= base_addr;
                len_q    <= length;
                issued_q <= '0;
            end else if (mem_rd_s) begin
                issued_q <= issued_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    rdbk_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (RESET),
        .push  (push_s),
        .pop   (pop_s),
        .din   (mem_rdata),
        .dout  (out_data),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .count (fifo_count_s)
    );

    assign mem_rd    = mem_rd_s;
    assign mem_addr  = (state_q == ST_ISSUE) ? (base_q + issued_q) : '0;
    assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign mux_sel   = busy ? MUX_RDBK : MUX_CORE;
    assign done      = (state_q == ST_DONE);
    assign out_valid = !fifo_empty_s;

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    // Running sum of accepted words, restarted by each accepted start.
    always_ff @(posedge clk) begin
        if (RESET) begin
            checksum_q <= '0;
        end else if (start_acc_s) begin
            checksum_q <= '0;
        end else if (pop_s) begin
            checksum_q <= checksum_q + out_data;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule
